// File: rtl/altera_emif_ddr4_model_bcom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : altera_emif_ddr4_model_bcom_pkg
// Description : Shared types and constants for the LRDIMM BCOM bus. Used by
//               the RCD-side serializer and the data-buffer-side decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package altera_emif_ddr4_model_bcom_pkg;

    // Decoded host command types
    typedef enum logic [1:0] {
        CMD_NOP = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2,
        CMD_BCW = 2'd3
    } cmd_type_e;

    // Serializer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } bcom_state_e;

    // BCOM opcodes (first nibble of each frame)
    localparam logic [3:0] c_opc_rd  = 4'h1;
    localparam logic [3:0] c_opc_wr  = 4'h2;
    localparam logic [3:0] c_opc_bcw = 4'h3;

    // Frame lengths in nibbles, parity nibble included
    localparam logic [2:0] c_len_rdwr = 3'd3;
    localparam logic [2:0] c_len_bcw  = 3'd6;

    // XOR of up to five nibbles; unused upper nibbles are zero and do not
    // disturb the result, so short frames share the same function.
    function automatic logic [3:0] bcom_parity(input logic [19:0] nibs);
        logic [3:0] p;
        p = 4'h0;
        for (int i = 0; i < 5; i++) begin
            p = p ^ nibs[4*i +: 4];
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/altera_emif_ddr4_model_bcom_odt_timer.sv
`default_nettype none
// ============================================================================
// Module      : altera_emif_ddr4_model_bcom_odt_timer
// Description : Retriggerable down-counter producing the buffer ODT enable.
//               A load restarts the count at ODT_CYCLES; BODT is high while
//               the count is non-zero, including the load cycle itself.
// Revision    : 1.0 - initial release
// ============================================================================
module altera_emif_ddr4_model_bcom_odt_timer #(
    parameter int unsigned ODT_CYCLES = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic bodt
);

    localparam logic [7:0] c_odt_load = 8'(ODT_CYCLES);

    logic [7:0] r_cnt;
    logic       r_bodt;
    logic [7:0] w_cnt_nxt;

    // Next count: reload on a write opcode, otherwise decay toward zero
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (load) begin
            w_cnt_nxt = c_odt_load;
        end else if (r_cnt != 8'd0) begin
            w_cnt_nxt = r_cnt - 8'd1;
        end
    end

    // Counter and registered enable, so BODT rises with the opcode nibble
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= 8'd0;
            r_bodt <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_bodt <= (w_cnt_nxt != 8'd0);
        end
    end

    assign bodt = r_bodt;

endmodule
`default_nettype wire

// File: rtl/altera_emif_ddr4_model_rcd_bcom_tx.sv
`default_nettype none
// ============================================================================
// Module      : altera_emif_ddr4_model_rcd_bcom_tx
// Description : RCD-side BCOM serializer. Accepts RD/WR/BCW commands over a
//               valid/ready handshake and shifts them out as parity-protected
//               nibble frames on BCOM, with BCKE and BODT alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module altera_emif_ddr4_model_rcd_bcom_tx
    import altera_emif_ddr4_model_bcom_pkg::*;
#(
    parameter int unsigned MIN_GAP    = 1,
    parameter int unsigned ODT_CYCLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [1:0] cmd_rank,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    input  logic       cke_in,
    output logic [3:0] BCOM,
    output logic       BCKE,
    output logic       BODT,
    output logic       frame_done
);

    localparam bit         c_no_gap   = (MIN_GAP == 0);
    localparam logic [3:0] c_gap_init = 4'((MIN_GAP == 0) ? 0 : MIN_GAP - 1);

    bcom_state_e r_state, w_state_nxt;
    logic [19:0] r_frame, w_frame_nxt;     // nibbles still to send, next at [3:0]
    logic [2:0]  r_left,  w_left_nxt;      // nibbles remaining after the current one
    logic [3:0]  r_gap,   w_gap_nxt;       // gap cycles remaining after the current one
    logic [3:0]  r_bcom,  w_bcom_nxt;
    logic        r_frame_done, w_frame_done_nxt;
    logic        r_bcke;

    cmd_type_e   w_type;
    logic        w_start;
    logic [19:0] w_body;
    logic [3:0]  w_par;
    logic [23:0] w_full;
    logic [2:0]  w_len;

    assign w_type  = cmd_type_e'(cmd_type);
    assign w_start = cmd_valid && cmd_ready && (w_type != CMD_NOP);

    // Ready depends on state only; a new frame may follow the last nibble
    // directly when no gap is configured, or the last gap cycle otherwise.
    always_comb begin
        cmd_ready = 1'b0;
        if (!reset) begin
            cmd_ready = (r_state == ST_IDLE)
                     || ((r_state == ST_SEND) && (r_left == 3'd0) && c_no_gap)
                     || ((r_state == ST_GAP)  && (r_gap == 4'd0));
        end
    end

    // Build the complete frame, parity included, from the command fields
    always_comb begin
        w_body = 20'h0;
        w_len  = c_len_rdwr;
        case (w_type)
            CMD_BCW: begin
                w_body = {cmd_data[3:0], cmd_data[7:4], cmd_addr[3:0], cmd_addr[7:4], c_opc_bcw};
                w_len  = c_len_bcw;
            end
            CMD_WR:  w_body = {12'h0, 2'b00, cmd_rank, c_opc_wr};
            default: w_body = {12'h0, 2'b00, cmd_rank, c_opc_rd};
        endcase
        w_par = bcom_parity(w_body);
        if (w_type == CMD_BCW) begin
            w_full = {w_par, w_body};
        end else begin
            w_full = {12'h0, w_par, w_body[7:0]};
        end
    end

    // FSM next-state and next-output logic; nibble 0 is driven straight from
    // the capture so it appears the cycle after the handshake.
    always_comb begin
        w_state_nxt      = r_state;
        w_frame_nxt      = r_frame;
        w_left_nxt       = r_left;
        w_gap_nxt        = r_gap;
        w_bcom_nxt       = 4'h0;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_SEND;
                    w_bcom_nxt  = w_full[3:0];
                    w_frame_nxt = w_full[23:4];
                    w_left_nxt  = w_len - 3'd1;
                end
            end
            ST_SEND: begin
                if (r_left != 3'd0) begin
                    w_bcom_nxt       = r_frame[3:0];
                    w_frame_nxt      = {4'h0, r_frame[19:4]};
                    w_left_nxt       = r_left - 3'd1;
                    w_frame_done_nxt = (r_left == 3'd1);
                end else if (w_start) begin
                    w_bcom_nxt  = w_full[3:0];
                    w_frame_nxt = w_full[23:4];
                    w_left_nxt  = w_len - 3'd1;
                end else if (!c_no_gap) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = c_gap_init;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap != 4'd0) begin
                    w_gap_nxt = r_gap - 4'd1;
                end else if (w_start) begin
                    w_state_nxt = ST_SEND;
                    w_bcom_nxt  = w_full[3:0];
                    w_frame_nxt = w_full[23:4];
                    w_left_nxt  = w_len - 3'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state and output registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_frame      <= 20'h0;
            r_left       <= 3'd0;
            r_gap        <= 4'd0;
            r_bcom       <= 4'h0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame      <= w_frame_nxt;
            r_left       <= w_left_nxt;
            r_gap        <= w_gap_nxt;
            r_bcom       <= w_bcom_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // BCKE is a plain one-cycle delay of the host clock-enable
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcke <= 1'b0;
        end else begin
            r_bcke <= cke_in;
        end
    end

    altera_emif_ddr4_model_bcom_odt_timer #(
        .ODT_CYCLES (ODT_CYCLES)
    ) u_odt_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_start && (w_type == CMD_WR)),
        .bodt  (BODT)
    );

    assign BCOM       = r_bcom;
    assign BCKE       = r_bcke;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_altera_emif_ddr4_model_rcd_bcom_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_altera_emif_ddr4_model_rcd_bcom_tx
// Description : Directed self-checking bench for the BCOM serializer. One
//               instance uses MIN_GAP=1, a second MIN_GAP=0 for back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_altera_emif_ddr4_model_rcd_bcom_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_valid0;
    logic [1:0] cmd_type, cmd_rank;
    logic [7:0] cmd_addr, cmd_data;
    logic       cke_in;

    logic       cmd_ready, cmd_ready0;
    logic [3:0] bcom, bcom0;
    logic       bcke, bcke0;
    logic       bodt, bodt0;
    logic       fdone, fdone0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    altera_emif_ddr4_model_rcd_bcom_tx #(.MIN_GAP(1), .ODT_CYCLES(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_rank   (cmd_rank),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cke_in     (cke_in),
        .BCOM       (bcom),
        .BCKE       (bcke),
        .BODT       (bodt),
        .frame_done (fdone)
    );

    altera_emif_ddr4_model_rcd_bcom_tx #(.MIN_GAP(0), .ODT_CYCLES(6)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid0),
        .cmd_ready  (cmd_ready0),
        .cmd_type   (cmd_type),
        .cmd_rank   (cmd_rank),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cke_in     (cke_in),
        .BCOM       (bcom0),
        .BCKE       (bcke0),
        .BODT       (bodt0),
        .frame_done (fdone0)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock, then check BCOM, frame_done and BODT of the MIN_GAP=1 instance
    task automatic step_chk(input string tag, input logic [3:0] eb, input logic efd, input logic eodt);
        tick();
        check_val({tag, ".bcom"}, 32'(bcom), 32'(eb));
        check_val({tag, ".fd"},   32'(fdone), 32'(efd));
        check_val({tag, ".odt"},  32'(bodt), 32'(eodt));
    endtask

    // Same for the MIN_GAP=0 instance
    task automatic step_chk0(input string tag, input logic [3:0] eb, input logic efd);
        tick();
        check_val({tag, ".bcom0"}, 32'(bcom0), 32'(eb));
        check_val({tag, ".fd0"},   32'(fdone0), 32'(efd));
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_valid0 = 1'b0;
        cmd_type   = 2'd0;
        cmd_rank   = 2'd0;
        cmd_addr   = 8'h00;
        cmd_data   = 8'h00;
        cke_in     = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check_val("rst.bcom",  32'(bcom),  32'h0);
        check_val("rst.bodt",  32'(bodt),  32'h0);
        check_val("rst.fd",    32'(fdone), 32'h0);
        check_val("rst.bcke",  32'(bcke),  32'h0);
        check_val("rst.ready", 32'(cmd_ready), 32'h0);
        reset = 1'b0;
        #1;
        check_val("rst.ready_after", 32'(cmd_ready), 32'h1);

        // BCKE follows cke_in one cycle later
        cke_in = 1'b1;
        tick();
        check_val("bcke.hi", 32'(bcke), 32'h1);
        cke_in = 1'b0;
        tick();
        check_val("bcke.lo", 32'(bcke), 32'h0);

        // RD rank 2: 1,2,3 then gap
        cmd_valid = 1'b1; cmd_type = 2'd1; cmd_rank = 2'd2;
        step_chk("rd.n0", 4'h1, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        check_val("rd.ready_busy", 32'(cmd_ready), 32'h0);
        step_chk("rd.n1", 4'h2, 1'b0, 1'b0);
        step_chk("rd.n2", 4'h3, 1'b1, 1'b0);
        step_chk("rd.gap", 4'h0, 1'b0, 1'b0);
        check_val("rd.ready_gap", 32'(cmd_ready), 32'h1);
        step_chk("rd.idle", 4'h0, 1'b0, 1'b0);

        // WR rank 1: 2,1,3 with BODT high 6 cycles from the opcode
        cmd_valid = 1'b1; cmd_type = 2'd2; cmd_rank = 2'd1;
        step_chk("wr.n0", 4'h2, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        step_chk("wr.n1", 4'h1, 1'b0, 1'b1);
        step_chk("wr.n2", 4'h3, 1'b1, 1'b1);
        step_chk("wr.c3", 4'h0, 1'b0, 1'b1);
        step_chk("wr.c4", 4'h0, 1'b0, 1'b1);
        step_chk("wr.c5", 4'h0, 1'b0, 1'b1);
        step_chk("wr.c6", 4'h0, 1'b0, 1'b0);

        // BCW addr A5 data 3C: 3,A,5,3,C,3 with ready low across the frame
        cmd_valid = 1'b1; cmd_type = 2'd3; cmd_addr = 8'hA5; cmd_data = 8'h3C;
        step_chk("bcw.n0", 4'h3, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        check_val("bcw.rdy0", 32'(cmd_ready), 32'h0);
        step_chk("bcw.n1", 4'hA, 1'b0, 1'b0);
        check_val("bcw.rdy1", 32'(cmd_ready), 32'h0);
        step_chk("bcw.n2", 4'h5, 1'b0, 1'b0);
        step_chk("bcw.n3", 4'h3, 1'b0, 1'b0);
        step_chk("bcw.n4", 4'hC, 1'b0, 1'b0);
        step_chk("bcw.n5", 4'h3, 1'b1, 1'b0);
        check_val("bcw.rdy5", 32'(cmd_ready), 32'h0);
        step_chk("bcw.gap", 4'h0, 1'b0, 1'b0);
        check_val("bcw.rdy_gap", 32'(cmd_ready), 32'h1);
        step_chk("bcw.idle", 4'h0, 1'b0, 1'b0);

        // Two RDs held valid, MIN_GAP=1: 1,0,1,0,1,3,2,0
        cmd_valid = 1'b1; cmd_type = 2'd1; cmd_rank = 2'd0;
        step_chk("b2b.a0", 4'h1, 1'b0, 1'b0);
        cmd_rank = 2'd3;
        step_chk("b2b.a1", 4'h0, 1'b0, 1'b0);
        step_chk("b2b.a2", 4'h1, 1'b1, 1'b0);
        step_chk("b2b.gap", 4'h0, 1'b0, 1'b0);
        step_chk("b2b.b0", 4'h1, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        step_chk("b2b.b1", 4'h3, 1'b0, 1'b0);
        step_chk("b2b.b2", 4'h2, 1'b1, 1'b0);
        step_chk("b2b.end", 4'h0, 1'b0, 1'b0);
        step_chk("b2b.idle", 4'h0, 1'b0, 1'b0);

        // Same pair on the MIN_GAP=0 instance: 1,0,1,1,3,2
        cmd_valid0 = 1'b1; cmd_type = 2'd1; cmd_rank = 2'd0;
        step_chk0("ng.a0", 4'h1, 1'b0);
        cmd_rank = 2'd3;
        step_chk0("ng.a1", 4'h0, 1'b0);
        step_chk0("ng.a2", 4'h1, 1'b1);
        check_val("ng.ready_last", 32'(cmd_ready0), 32'h1);
        step_chk0("ng.b0", 4'h1, 1'b0);
        cmd_valid0 = 1'b0;
        step_chk0("ng.b1", 4'h3, 1'b0);
        step_chk0("ng.b2", 4'h2, 1'b1);
        step_chk0("ng.idle", 4'h0, 1'b0);
        check_val("ng.ready_idle", 32'(cmd_ready0), 32'h1);

        // WR retrigger: second WR opcode 4 cycles after the first
        cmd_valid = 1'b1; cmd_type = 2'd2; cmd_rank = 2'd0;
        step_chk("rt.c0", 4'h2, 1'b0, 1'b1);
        step_chk("rt.c1", 4'h0, 1'b0, 1'b1);
        step_chk("rt.c2", 4'h2, 1'b1, 1'b1);
        step_chk("rt.c3", 4'h0, 1'b0, 1'b1);
        step_chk("rt.c4", 4'h2, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        step_chk("rt.c5", 4'h0, 1'b0, 1'b1);
        step_chk("rt.c6", 4'h2, 1'b1, 1'b1);
        step_chk("rt.c7", 4'h0, 1'b0, 1'b1);
        step_chk("rt.c8", 4'h0, 1'b0, 1'b1);
        step_chk("rt.c9", 4'h0, 1'b0, 1'b1);
        step_chk("rt.c10", 4'h0, 1'b0, 1'b0);

        // Reset during nibble 2 of a BCW
        cmd_valid = 1'b1; cmd_type = 2'd3; cmd_addr = 8'hA5; cmd_data = 8'h3C;
        step_chk("mr.n0", 4'h3, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        step_chk("mr.n1", 4'hA, 1'b0, 1'b0);
        step_chk("mr.n2", 4'h5, 1'b0, 1'b0);
        reset = 1'b1;
        step_chk("mr.rst", 4'h0, 1'b0, 1'b0);
        check_val("mr.ready_in_rst", 32'(cmd_ready), 32'h0);
        reset = 1'b0;
        #1;
        check_val("mr.ready_after", 32'(cmd_ready), 32'h1);
        step_chk("mr.quiet0", 4'h0, 1'b0, 1'b0);
        step_chk("mr.quiet1", 4'h0, 1'b0, 1'b0);
        step_chk("mr.quiet2", 4'h0, 1'b0, 1'b0);
        cmd_valid = 1'b1; cmd_type = 2'd1; cmd_rank = 2'd1;
        step_chk("mr.rd0", 4'h1, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        step_chk("mr.rd1", 4'h1, 1'b0, 1'b0);
        step_chk("mr.rd2", 4'h0, 1'b1, 1'b0);
        step_chk("mr.rd_end", 4'h0, 1'b0, 1'b0);

        // NOP is accepted without sending anything
        cmd_valid = 1'b1; cmd_type = 2'd0;
        step_chk("nop.c0", 4'h0, 1'b0, 1'b0);
        check_val("nop.ready", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b0;
        step_chk("nop.c1", 4'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
